// File: rtl/riscv_soft_fetch_pkg.sv
// Shared constants and types for the riscv-soft fetch front end.
package riscv_soft_fetch_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  localparam logic [1:0] PC_SRC_PLUS_4 = 2'd0;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd1;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd2;

  // Source feeding the EX-facing instruction register on an unstalled cycle.
  typedef enum logic [1:0] {
    EX_SEL_NOP  = 2'd0,
    EX_SEL_BUF  = 2'd1,
    EX_SEL_RESP = 2'd2
  } ex_sel_e;

endpackage

// File: rtl/riscv_soft_fetch_if.sv
// Instruction-cache request/response channel between fetch (master) and i_cache (slave).
interface riscv_soft_fetch_if
  import riscv_soft_fetch_pkg::*;
#(
  parameter int unsigned XPR_LEN = 32
) ();

  logic               req_valid;
  logic               req_ready;
  logic [XPR_LEN-1:0] req_addr;
  logic               resp_valid;
  logic [INST_W-1:0]  resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/riscv_soft_ibuf.sv
// Single-entry {PC, instruction} holding register for responses that land while IF is stalled.
module riscv_soft_ibuf
  import riscv_soft_fetch_pkg::*;
#(
  parameter int unsigned XPR_LEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [XPR_LEN-1:0] wr_pc,
  input  logic [INST_W-1:0]  wr_data,
  input  logic               rd_en,
  input  logic               flush,
  output logic               valid,
  output logic [XPR_LEN-1:0] pc,
  output logic [INST_W-1:0]  data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      data  <= NOP;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      pc    <= wr_pc;
      data  <= wr_data;
    end else if (rd_en) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/riscv_soft_fetch.sv
// PIF/IF front end: owns fetch PC, issues one-word i_cache requests, feeds instruction_EX/PC_EX.
module riscv_soft_fetch
  import riscv_soft_fetch_pkg::*;
#(
  parameter int unsigned        XPR_LEN  = 32,
  parameter logic [XPR_LEN-1:0] RESET_PC = XPR_LEN'(32'h0000_0200)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_IF,
  input  logic [1:0]           next_PC_src_PIF,
  input  logic                 branch_taken_EX,
  input  logic [XPR_LEN-1:0]   jump_target_EX,
  input  logic [XPR_LEN-1:0]   branch_target_EX,
  riscv_soft_fetch_if.master   i_cache,
  output logic [INST_W-1:0]    instruction_EX,
  output logic [XPR_LEN-1:0]   PC_EX,
  output logic                 valid_EX
);

  logic [XPR_LEN-1:0] fetch_pc;
  logic [XPR_LEN-1:0] req_pc;
  logic               outstanding;
  logic               drop;

  logic               buf_valid;
  logic [XPR_LEN-1:0] buf_pc;
  logic [INST_W-1:0]  buf_data;

  logic               redirect_c;
  logic [XPR_LEN-1:0] target_c;
  logic               resp_fire_c;
  logic               resp_live_c;
  logic               issue_c;
  logic               accept_c;
  ex_sel_e            ex_sel_c;

  // Redirect, issue and EX-source decisions for this cycle.
  always_comb begin
    redirect_c  = 1'b0;
    target_c    = branch_target_EX;
    resp_fire_c = 1'b0;
    resp_live_c = 1'b0;
    issue_c     = 1'b0;
    accept_c    = 1'b0;
    ex_sel_c    = EX_SEL_NOP;

    redirect_c = !stall_IF && valid_EX &&
                 ((next_PC_src_PIF == PC_SRC_JUMP) ||
                  ((next_PC_src_PIF == PC_SRC_BRANCH) && branch_taken_EX));
    if (next_PC_src_PIF == PC_SRC_JUMP)
      target_c = {jump_target_EX[XPR_LEN-1:1], 1'b0};

    // Responses with nothing outstanding are stale (e.g. issued before reset).
    resp_fire_c = i_cache.resp_valid && outstanding;
    resp_live_c = resp_fire_c && !drop && !redirect_c;

    issue_c  = !reset && !redirect_c && !buf_valid &&
               (!outstanding || (i_cache.resp_valid && !stall_IF));
    accept_c = issue_c && i_cache.req_ready;

    if (redirect_c)       ex_sel_c = EX_SEL_NOP;
    else if (buf_valid)   ex_sel_c = EX_SEL_BUF;
    else if (resp_live_c) ex_sel_c = EX_SEL_RESP;
  end

  assign i_cache.req_valid = issue_c;
  assign i_cache.req_addr  = fetch_pc;

  riscv_soft_ibuf #(.XPR_LEN(XPR_LEN)) u_ibuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (resp_live_c && stall_IF),
    .wr_pc   (req_pc),
    .wr_data (i_cache.resp_data),
    .rd_en   (!stall_IF && buf_valid),
    .flush   (redirect_c),
    .valid   (buf_valid),
    .pc      (buf_pc),
    .data    (buf_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc       <= RESET_PC;
      req_pc         <= '0;
      outstanding    <= 1'b0;
      drop           <= 1'b0;
      instruction_EX <= NOP;
      PC_EX          <= '0;
      valid_EX       <= 1'b0;
    end else begin
      if (redirect_c)    fetch_pc <= target_c;
      else if (accept_c) fetch_pc <= fetch_pc + XPR_LEN'(4);

      if (accept_c) req_pc <= fetch_pc;

      if (accept_c)         outstanding <= 1'b1;
      else if (resp_fire_c) outstanding <= 1'b0;

      // An in-flight request whose response has not yet come back must be discarded.
      if (redirect_c)       drop <= outstanding && !i_cache.resp_valid;
      else if (resp_fire_c) drop <= 1'b0;

      if (!stall_IF) begin
        case (ex_sel_c)
          EX_SEL_BUF: begin
            instruction_EX <= buf_data;
            PC_EX          <= buf_pc;
            valid_EX       <= 1'b1;
          end
          EX_SEL_RESP: begin
            instruction_EX <= i_cache.resp_data;
            PC_EX          <= req_pc;
            valid_EX       <= 1'b1;
          end
          default: begin
            instruction_EX <= NOP;
            valid_EX       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
